// File: rtl/serial_pack_fifo.sv
// serial_pack_fifo: packs a 1-bit serial stream into DATA_WIDTH-bit words
// and queues completed words in a 2^ADDR_WIDTH-deep FIFO.
//
// Ports:
//   inClock        rising-edge clock
//   inReset        asynchronous active-low reset
//   inWriteEnable  sample inData this cycle
//   inData         serial data bit
//   inReadEnable   pop one word into outData
//   inFlush        synchronous clear of FIFO and packer (dominates)
//   outData        last popped word
//   outWordCount   stored words, 0..2^ADDR_WIDTH
//   outBitCount    bits held in the packer, 0..DATA_WIDTH-1
//   outFull/outEmpty/outAlmostFull/outAlmostEmpty  occupancy flags
//   outDone        one-cycle pulse after a word commit
//   outWriteError  one-cycle pulse after a rejected completing bit
//   outReadError   one-cycle pulse after a read on empty
module serial_pack_fifo #(
   parameter int unsigned DATA_WIDTH         = 4,
   parameter int unsigned ADDR_WIDTH         = 2,
   parameter int unsigned ALMOST_FULL_LEVEL  = 3,
   parameter int unsigned ALMOST_EMPTY_LEVEL = 1,
   parameter int unsigned MSB_FIRST          = 1
) (
   input  logic                          inClock,
   input  logic                          inReset,
   input  logic                          inWriteEnable,
   input  logic                          inData,
   input  logic                          inReadEnable,
   input  logic                          inFlush,
   output logic [DATA_WIDTH-1:0]         outData,
   output logic [ADDR_WIDTH:0]           outWordCount,
   output logic [$clog2(DATA_WIDTH)-1:0] outBitCount,
   output logic                          outFull,
   output logic                          outEmpty,
   output logic                          outAlmostFull,
   output logic                          outAlmostEmpty,
   output logic                          outDone,
   output logic                          outWriteError,
   output logic                          outReadError
);

   localparam int unsigned BCW   = $clog2(DATA_WIDTH);
   localparam int unsigned CW    = ADDR_WIDTH + 1;
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] pack_q, pack_d;
   logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  afull_q, afull_d;
   logic                  aempty_q, aempty_d;
   logic                  done_q, done_d;
   logic                  werr_q, werr_d;
   logic                  rerr_q, rerr_d;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  pop_c;
   logic                  last_bit_c;
   logic                  commit_c;
   logic                  mem_we_c;
   logic [BCW-1:0]        pos_c;
   logic [DATA_WIDTH-1:0] word_c;

   // Packer insertion point and accept/commit decisions
   always_comb begin
      pop_c      = inReadEnable && !empty_q;
      last_bit_c = (bit_cnt_q == BCW'(DATA_WIDTH - 1));
      // Only the completing bit needs room; a same-cycle pop frees a slot
      commit_c   = inWriteEnable && last_bit_c && (!full_q || pop_c);
      mem_we_c   = commit_c && !inFlush;
      pos_c      = (MSB_FIRST != 0) ? (BCW'(DATA_WIDTH - 1) - bit_cnt_q) : bit_cnt_q;
      word_c        = pack_q;
      word_c[pos_c] = inData;
   end

   // Next-state for pointers, count, packer, read data and strobes
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      pack_d    = pack_q;
      bit_cnt_d = bit_cnt_q;
      data_d    = data_q;
      done_d    = 1'b0;
      werr_d    = 1'b0;
      rerr_d    = 1'b0;

      if (inFlush) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         pack_d    = '0;
         bit_cnt_d = '0;
      end else begin
         if (inWriteEnable) begin
            if (!last_bit_c) begin
               pack_d    = word_c;
               bit_cnt_d = bit_cnt_q + BCW'(1);
            end else if (commit_c) begin
               pack_d    = '0;
               bit_cnt_d = '0;
               wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
               done_d    = 1'b1;
            end else begin
               werr_d = 1'b1;
            end
         end
         if (inReadEnable) begin
            if (pop_c) begin
               data_d   = mem_q[rd_ptr_q];
               rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            end else begin
               rerr_d = 1'b1;
            end
         end
         count_d = count_q + CW'(commit_c) - CW'(pop_c);
      end

      full_d   = (count_d == CW'(DEPTH));
      empty_d  = (count_d == '0);
      afull_d  = (32'(count_d) >= ALMOST_FULL_LEVEL);
      aempty_d = (32'(count_d) <= ALMOST_EMPTY_LEVEL);
   end

   // State registers
   always_ff @(posedge inClock or negedge inReset) begin
      if (!inReset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         pack_q    <= '0;
         bit_cnt_q <= '0;
         data_q    <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         afull_q   <= 1'b0;
         aempty_q  <= 1'b1; // occupancy 0 never exceeds an unsigned level
         done_q    <= 1'b0;
         werr_q    <= 1'b0;
         rerr_q    <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         pack_q    <= pack_d;
         bit_cnt_q <= bit_cnt_d;
         data_q    <= data_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
         afull_q   <= afull_d;
         aempty_q  <= aempty_d;
         done_q    <= done_d;
         werr_q    <= werr_d;
         rerr_q    <= rerr_d;
      end
   end

   // Word storage; contents are don't-care until written, so no reset
   always_ff @(posedge inClock) begin
      if (mem_we_c) begin
         mem_q[wr_ptr_q] <= word_c;
      end
   end

   assign outData        = data_q;
   assign outWordCount   = count_q;
   assign outBitCount    = bit_cnt_q;
   assign outFull        = full_q;
   assign outEmpty       = empty_q;
   assign outAlmostFull  = afull_q;
   assign outAlmostEmpty = aempty_q;
   assign outDone        = done_q;
   assign outWriteError  = werr_q;
   assign outReadError   = rerr_q;

endmodule

// File: tb/tb_serial_pack_fifo.sv
// Scoreboard bench for serial_pack_fifo: one MSB-first and one LSB-first
// instance share the stimulus; popped words are checked by monitors.
module tb_serial_pack_fifo;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic wr = 1'b0, din = 1'b0, rd = 1'b0, fl = 1'b0;

   logic [3:0] m_data, l_data;
   logic [2:0] m_cnt, l_cnt;
   logic [1:0] m_bits, l_bits;
   logic m_full, m_empty, m_af, m_ae, m_done, m_werr, m_rerr;
   logic l_full, l_empty, l_af, l_ae, l_done, l_werr, l_rerr;

   int checks = 0;
   int failures = 0;
   logic [3:0] exp_m[$];
   logic [3:0] exp_l[$];

   always #5 clk = ~clk;

   serial_pack_fifo #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .ALMOST_FULL_LEVEL(3),
                      .ALMOST_EMPTY_LEVEL(1), .MSB_FIRST(1)) dut_msb (
      .inClock(clk), .inReset(rst_n), .inWriteEnable(wr), .inData(din),
      .inReadEnable(rd), .inFlush(fl), .outData(m_data), .outWordCount(m_cnt),
      .outBitCount(m_bits), .outFull(m_full), .outEmpty(m_empty),
      .outAlmostFull(m_af), .outAlmostEmpty(m_ae), .outDone(m_done),
      .outWriteError(m_werr), .outReadError(m_rerr));

   serial_pack_fifo #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .ALMOST_FULL_LEVEL(3),
                      .ALMOST_EMPTY_LEVEL(1), .MSB_FIRST(0)) dut_lsb (
      .inClock(clk), .inReset(rst_n), .inWriteEnable(wr), .inData(din),
      .inReadEnable(rd), .inFlush(fl), .outData(l_data), .outWordCount(l_cnt),
      .outBitCount(l_bits), .outFull(l_full), .outEmpty(l_empty),
      .outAlmostFull(l_af), .outAlmostEmpty(l_ae), .outDone(l_done),
      .outWriteError(l_werr), .outReadError(l_rerr));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // One clock: drive at negedge, return 1 time unit after the rising edge
   task automatic step(input logic we, input logic d, input logic re, input logic f);
      @(negedge clk);
      wr = we; din = d; rd = re; fl = f;
      @(posedge clk);
      #1;
      wr = 1'b0; din = 1'b0; rd = 1'b0; fl = 1'b0;
   endtask

   // Send four bits, first bit = b[3]
   task automatic put_word(input logic [3:0] b);
      for (int i = 3; i >= 0; i--) step(1'b1, b[i], 1'b0, 1'b0);
   endtask

   task automatic rd_word(input logic [3:0] em, input logic [3:0] el);
      exp_m.push_back(em);
      exp_l.push_back(el);
      step(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   // Monitors: a pop is accepted when read is requested on a non-empty FIFO
   always @(posedge clk) begin
      if (rst_n && rd && !fl && !m_empty) begin
         #1;
         checks++;
         if (exp_m.size() == 0) begin
            failures++;
            $display("FAIL msb_pop unexpected actual=%0h required=none", m_data);
         end else begin
            logic [3:0] e;
            e = exp_m.pop_front();
            if (m_data !== e) begin
               failures++;
               $display("FAIL msb_pop actual=%0h required=%0h", m_data, e);
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rst_n && rd && !fl && !l_empty) begin
         #1;
         checks++;
         if (exp_l.size() == 0) begin
            failures++;
            $display("FAIL lsb_pop unexpected actual=%0h required=none", l_data);
         end else begin
            logic [3:0] e;
            e = exp_l.pop_front();
            if (l_data !== e) begin
               failures++;
               $display("FAIL lsb_pop actual=%0h required=%0h", l_data, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] words [4];
      words[0] = 4'hA; words[1] = 4'hD; words[2] = 4'h7; words[3] = 4'hF;

      // Reset
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_empty", 32'(m_empty), 1);
      chk("rst_count", 32'(m_cnt), 0);
      chk("rst_data", 32'(m_data), 0);
      chk("rst_bits", 32'(m_bits), 0);
      chk("rst_full", 32'(m_full), 0);
      chk("rst_afull", 32'(m_af), 0);
      chk("rst_aempty", 32'(m_ae), 1);
      chk("rst_strobes", 32'({m_done, m_werr, m_rerr}), 0);
      chk("rst_lsb_data", 32'(l_data), 0);

      // Fill with four words, idle gap after each
      for (int w = 0; w < 4; w++) begin
         put_word(words[w]);
         chk("fill_done", 32'(m_done), 1);
         chk("fill_count", 32'(m_cnt), 32'(w + 1));
         chk("fill_afull", 32'(m_af), 32'((w + 1) >= 3));
         chk("fill_aempty", 32'(m_ae), 32'((w + 1) <= 1));
         step(1'b0, 1'b0, 1'b0, 1'b0);
         chk("fill_done_pulse", 32'(m_done), 0);
      end
      chk("fill_full", 32'(m_full), 1);

      // Drain: MSB-first A,D,7,F ; LSB-first 5,B,E,F
      rd_word(4'hA, 4'h5);
      rd_word(4'hD, 4'hB);
      rd_word(4'h7, 4'hE);
      rd_word(4'hF, 4'hF);
      chk("drain_empty", 32'(m_empty), 1);
      chk("drain_count", 32'(m_cnt), 0);
      chk("drain_lsb_empty", 32'(l_empty), 1);

      // Refill, then partial bits while full
      for (int w = 0; w < 4; w++) put_word(words[w]);
      chk("refull_full", 32'(m_full), 1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("partial_bits", 32'(m_bits), 3);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("werr_pulse", 32'(m_werr), 1);
      chk("werr_bits_hold", 32'(m_bits), 3);
      chk("werr_no_done", 32'(m_done), 0);
      chk("werr_count", 32'(m_cnt), 4);
      // Retry completing bit with a pop: word 1011 -> msb B, lsb D
      exp_m.push_back(4'hA);
      exp_l.push_back(4'h5);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("full_commit_pop_count", 32'(m_cnt), 4);
      chk("full_commit_pop_done", 32'(m_done), 1);
      chk("full_commit_pop_werr", 32'(m_werr), 0);
      chk("full_commit_pop_bits", 32'(m_bits), 0);
      rd_word(4'hD, 4'hB);
      rd_word(4'h7, 4'hE);
      rd_word(4'hF, 4'hF);
      rd_word(4'hB, 4'hD);
      chk("wrap_empty", 32'(m_empty), 1);

      // Read on empty
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("rerr_pulse", 32'(m_rerr), 1);
      chk("rerr_data_hold", 32'(m_data), 32'h B);
      chk("rerr_lsb_data_hold", 32'(l_data), 32'h D);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("rerr_pulse_end", 32'(m_rerr), 0);

      // Flush with write and read in the same cycle
      put_word(4'hA);
      put_word(4'hD);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("preflush_count", 32'(m_cnt), 2);
      chk("preflush_bits", 32'(m_bits), 2);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("flush_count", 32'(m_cnt), 0);
      chk("flush_bits", 32'(m_bits), 0);
      chk("flush_empty", 32'(m_empty), 1);
      chk("flush_data_hold", 32'(m_data), 32'h B);
      chk("flush_strobes", 32'({m_done, m_werr, m_rerr}), 0);

      // Asynchronous reset mid-word
      put_word(4'hC);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("pre_areset_bits", 32'(m_bits), 2);
      chk("pre_areset_count", 32'(m_cnt), 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_count", 32'(m_cnt), 0);
      chk("areset_bits", 32'(m_bits), 0);
      chk("areset_data", 32'(m_data), 0);
      chk("areset_empty", 32'(m_empty), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Commit into empty with same-cycle pop: no bypass, read error
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("nobypass_rerr", 32'(m_rerr), 1);
      chk("nobypass_done", 32'(m_done), 1);
      chk("nobypass_count", 32'(m_cnt), 1);
      chk("nobypass_data", 32'(m_data), 0);
      rd_word(4'hF, 4'hF);
      chk("final_empty", 32'(m_empty), 1);

      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("sb_drain_msb", 32'(exp_m.size()), 0);
      chk("sb_drain_lsb", 32'(exp_l.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
